// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the block-RAM controller FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StStall
  } bram_state_e;

endpackage

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite bus bundle between a master/interconnect and the block-RAM slave.
interface ahb_bram_ctrl_if;

  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

endinterface

// File: rtl/ahb_be_decode.sv
// Combinational AHB HSIZE/HADDR[1:0] to 4-bit byte-lane enable decode.
module ahb_be_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] haddr_i,
  output logic [3:0] be_o
);

  always_comb begin
    be_o = 4'b1111;
    case (hsize_i)
      HSIZE_BYTE: be_o = 4'b0001 << haddr_i;
      HSIZE_HALF: be_o = haddr_i[1] ? 4'b1100 : 4'b0011;
      default:    be_o = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave for a byte-writable dual-port block RAM (write port A, read port B).
// Define BRAM_FWD_EN to forward write data into hazard reads instead of stalling.
module ahb_bram_ctrl
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  ahb_bram_ctrl_if.slave        ahb,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [31:0]           bram_dina,
  output logic [3:0]            bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [31:0]           bram_doutb
);

  bram_state_e           state_q, state_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]            wr_be_q, wr_be_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic                  ready;
  logic                  accept;
  logic                  hazard;
  logic [3:0]            addr_be;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [31:0]           rd_data;

  logic unused_bits;
  assign unused_bits = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

  ahb_be_decode u_be_decode (
    .hsize_i (ahb.HSIZE),
    .haddr_i (ahb.HADDR[1:0]),
    .be_o    (addr_be)
  );

  assign haddr_word = ahb.HADDR[ADDR_WIDTH+1:2];
  assign ready      = (state_q != StStall);
  assign accept     = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY & ready;
  // Read of the word whose write data phase is happening right now.
  assign hazard     = accept & ~ahb.HWRITE & wr_pend_q & (haddr_word == wr_addr_q);

  always_comb begin
    state_d = StIdle;
    if (state_q == StStall) begin
      state_d = StRd;
    end else if (accept) begin
      if (ahb.HWRITE) begin
        state_d = StWr;
      end else begin
`ifdef BRAM_FWD_EN
        state_d = StRd;
`else
        state_d = hazard ? StStall : StRd;
`endif
      end
    end
  end

  always_comb begin
    wr_pend_d = accept & ahb.HWRITE;
    wr_addr_d = wr_addr_q;
    wr_be_d   = wr_be_q;
    rd_addr_d = rd_addr_q;
    if (accept && ahb.HWRITE) begin
      wr_addr_d = haddr_word;
      wr_be_d   = addr_be;
    end
    if (accept && !ahb.HWRITE) begin
      rd_addr_d = haddr_word;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StIdle;
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_be_q   <= 4'b0000;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_pend_q <= wr_pend_d;
      wr_addr_q <= wr_addr_d;
      wr_be_q   <= wr_be_d;
      rd_addr_q <= rd_addr_d;
    end
  end

`ifdef BRAM_FWD_EN
  logic [31:0] fwd_data_q;
  logic [3:0]  fwd_be_q;

  // Capture the in-flight write so the next read data phase can overlay it.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      fwd_data_q <= 32'h0;
      fwd_be_q   <= 4'b0000;
    end else begin
      fwd_data_q <= ahb.HWDATA;
      fwd_be_q   <= hazard ? wr_be_q : 4'b0000;
    end
  end

  always_comb begin
    rd_data = bram_doutb;
    for (int i = 0; i < 4; i++) begin
      if (fwd_be_q[i]) begin
        rd_data[8*i +: 8] = fwd_data_q[8*i +: 8];
      end
    end
  end
`else
  assign rd_data = bram_doutb;
`endif

  always_comb begin
    bram_addra    = wr_addr_q;
    bram_dina     = ahb.HWDATA;
    bram_wea      = wr_pend_q ? wr_be_q : 4'b0000;
    // During a stall the RAM re-reads the held address to see the committed write.
    bram_addrb    = (state_q == StStall) ? rd_addr_q : haddr_word;
    ahb.HREADYOUT = ready;
    ahb.HRDATA    = (state_q == StRd) ? rd_data : 32'h0;
    ahb.HRESP     = HRESP_OKAY;
    if (HRESET) begin
      bram_addra    = '0;
      bram_dina     = 32'h0;
      bram_wea      = 4'b0000;
      ahb.HREADYOUT = 1'b1;
      ahb.HRDATA    = 32'h0;
    end
  end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Directed self-checking bench for ahb_bram_ctrl with a read-first block-RAM model.
module tb_ahb_bram_ctrl;
  import ahb_pkg::*;

  localparam int unsigned AW = 14;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic [31:0]   bram_dina, bram_doutb;
  logic [3:0]    bram_wea;

  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = 8'h0;
  logic [31:0]   pre_data = 32'h0;
  logic [31:0]   mem [0:255];

  int n_checks = 0;
  int n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_bram_ctrl_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .ahb        (bus),
    .bram_addra (bram_addra),
    .bram_dina  (bram_dina),
    .bram_wea   (bram_wea),
    .bram_addrb (bram_addrb),
    .bram_doutb (bram_doutb)
  );

  // Read-first RAM: doutb shows the word as it was before a same-edge write.
  always @(posedge HCLK) begin
    bram_doutb <= mem[bram_addrb[7:0]];
    for (int i = 0; i < 4; i++) begin
      if (bram_wea[i]) mem[bram_addra[7:0]][8*i +: 8] <= bram_dina[8*i +: 8];
    end
    if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] trans, input logic [31:0] addr, input logic [2:0] size,
                       input logic wr, input logic [31:0] wdata);
    bus.HSEL   = 1'b1;
    bus.HTRANS = trans;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    bus.HWRITE = wr;
    bus.HWDATA = wdata;
  endtask

  task automatic idle(input logic [31:0] wdata);
    drive(HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0, wdata);
  endtask

  task automatic settle();
    @(negedge HCLK);
  endtask

  task automatic next();
    @(posedge HCLK);
    #1;
  endtask

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] data);
    pre_addr = byte_addr[9:2];
    pre_data = data;
    pre_we   = 1'b1;
    next();
    pre_we   = 1'b0;
  endtask

  function automatic logic [31:0] stream_data(input int k);
    return 32'hC0DE_0000 + k;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET = 1'b1;
    idle(32'hFFFF_FFFF);
    next();
    preload(32'h10, 32'h1234_5678);
    preload(32'h30, 32'h1122_3344);
    preload(32'h50, 32'h0102_0304);
    preload(32'h64, 32'h6464_6464);

    settle();
    check_eq("rst_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check_eq("rst_hrdata", bus.HRDATA, 32'h0);
    check_eq("rst_wea", {28'h0, bram_wea}, 32'h0);
    check_eq("rst_dina", bram_dina, 32'h0);
    check_eq("rst_hresp", {31'h0, bus.HRESP}, 32'h0);
    next();
    HRESET = 1'b0;

    // Reset lands in the data phase of a write; the write must be dropped.
    drive(HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1, 32'h0);
    next();
    HRESET = 1'b1;
    idle(32'hAAAA_AAAA);
    settle();
    check_eq("rstmid_wea", {28'h0, bram_wea}, 32'h0);
    next();
    HRESET = 1'b0;
    idle(32'h0);
    settle();
    check_eq("rstmid_hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
    check_eq("rstmid_hrdata", bus.HRDATA, 32'h0);
    next();
    drive(HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0, 32'h0);
    settle();
    check_eq("rstmid_addrb", {18'h0, bram_addrb}, 32'h4);
    next();
    idle(32'h0);
    settle();
    check_eq("rstmid_rd", bus.HRDATA, 32'h1234_5678);
    next();

    // Word write, idle gap, read back.
    drive(HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b1, 32'h0);
    next();
    idle(32'hDEAD_BEEF);
    settle();
    check_eq("wr_wea", {28'h0, bram_wea}, 32'hF);
    check_eq("wr_addra", {18'h0, bram_addra}, 32'h8);
    check_eq("wr_dina", bram_dina, 32'hDEAD_BEEF);
    next();
    idle(32'h0);
    next();
    drive(HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0, 32'h0);
    next();
    idle(32'h0);
    settle();
    check_eq("rd_data", bus.HRDATA, 32'hDEAD_BEEF);
    check_eq("rd_ready", {31'h0, bus.HREADYOUT}, 32'h1);
    next();

    // Byte and halfword lanes on 0x11223344.
    drive(HTRANS_NONSEQ, 32'h31, HSIZE_BYTE, 1'b1, 32'h0);
    next();
    drive(HTRANS_NONSEQ, 32'h32, HSIZE_HALF, 1'b1, 32'h0000_AA00);
    settle();
    check_eq("byte_wea", {28'h0, bram_wea}, 32'h2);
    check_eq("byte_addra", {18'h0, bram_addra}, 32'hC);
    next();
    idle(32'h5566_0000);
    settle();
    check_eq("half_wea", {28'h0, bram_wea}, 32'hC);
    next();
    drive(HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b0, 32'h0);
    next();
    idle(32'h0);
    settle();
    check_eq("lanes_rd", bus.HRDATA, 32'h5566_AA44);
    next();

    // Read of the same word right after a write; next address phase is held on the bus.
    drive(HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b1, 32'h0);
    next();
    drive(HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b0, 32'hCAFE_F00D);
    settle();
    check_eq("haz_wr_ready", {31'h0, bus.HREADYOUT}, 32'h1);
    check_eq("haz_wea", {28'h0, bram_wea}, 32'hF);
    next();
    drive(HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0, 32'h0);
`ifndef BRAM_FWD_EN
    settle();
    check_eq("haz_stall", {31'h0, bus.HREADYOUT}, 32'h0);
    check_eq("haz_stall_addrb", {18'h0, bram_addrb}, 32'h10);
    next();
`endif
    settle();
    check_eq("haz_rd", bus.HRDATA, 32'hCAFE_F00D);
    check_eq("haz_rd_ready", {31'h0, bus.HREADYOUT}, 32'h1);
    next();
    idle(32'h0);
    settle();
    check_eq("haz_held_rd", bus.HRDATA, 32'hDEAD_BEEF);
    next();

    // Partial hazard: byte write into 0x01020304 then immediate word read.
    drive(HTRANS_NONSEQ, 32'h52, HSIZE_BYTE, 1'b1, 32'h0);
    next();
    drive(HTRANS_NONSEQ, 32'h50, HSIZE_WORD, 1'b0, 32'h00FF_0000);
    next();
    idle(32'h0);
`ifndef BRAM_FWD_EN
    settle();
    check_eq("merge_stall", {31'h0, bus.HREADYOUT}, 32'h0);
    next();
`endif
    settle();
    check_eq("merge_rd", bus.HRDATA, 32'h01FF_0304);
    next();

    // Back-to-back streaming writes then reads.
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        drive((k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h100 + 32'(4 * k), HSIZE_WORD, 1'b1,
              (k > 0) ? stream_data(k - 1) : 32'h0);
      end else begin
        idle(stream_data(7));
      end
      settle();
      check_eq($sformatf("stream_wr_ready%0d", k), {31'h0, bus.HREADYOUT}, 32'h1);
      if (k > 0) check_eq($sformatf("stream_wea%0d", k), {28'h0, bram_wea}, 32'hF);
      next();
    end
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) begin
        drive((k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 32'h100 + 32'(4 * k), HSIZE_WORD, 1'b0,
              32'h0);
      end else begin
        idle(32'h0);
      end
      settle();
      check_eq($sformatf("stream_rd_ready%0d", k), {31'h0, bus.HREADYOUT}, 32'h1);
      if (k > 0) check_eq($sformatf("stream_rd%0d", k), bus.HRDATA, stream_data(k - 1));
      next();
    end

    // Adjacent word read after write: no stall.
    drive(HTRANS_NONSEQ, 32'h60, HSIZE_WORD, 1'b1, 32'h0);
    next();
    drive(HTRANS_NONSEQ, 32'h64, HSIZE_WORD, 1'b0, 32'h6060_6060);
    settle();
    check_eq("adj_wr_ready", {31'h0, bus.HREADYOUT}, 32'h1);
    next();
    drive(HTRANS_NONSEQ, 32'h60, HSIZE_WORD, 1'b0, 32'h0);
    settle();
    check_eq("adj_rd_ready", {31'h0, bus.HREADYOUT}, 32'h1);
    check_eq("adj_rd", bus.HRDATA, 32'h6464_6464);
    next();
    idle(32'h0);
    settle();
    check_eq("adj_wr_rd", bus.HRDATA, 32'h6060_6060);
    next();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
